// File: rtl/pinlv_pkg.sv
// Shared constants, channel state type and saturating-increment helper for
// the pro_pinlv signal-measurement block.
package pinlv_pkg;

  localparam int unsigned CNT_W_DEF          = 32;
  localparam int unsigned GATE_CYCLES_DEF    = 50_000_000;   // 1 s at 50 MHz
  localparam int unsigned TIMEOUT_CYCLES_DEF = 100_000_000;  // 2 s at 50 MHz

  // Per-channel presence state.
  //   CH_WAIT  : no rise seen since reset; next rise only arms
  //   CH_ARMED : a rise has been seen; the next rise closes a period
  //   CH_LOST  : idle timeout expired; next rise clears the flag and arms
  typedef enum logic [1:0] {
    CH_WAIT  = 2'd0,
    CH_ARMED = 2'd1,
    CH_LOST  = 2'd2
  } ch_state_t;

  // Increment that sticks at max_v. Carried at 64 bits so every counter width
  // up to 64 can share it; callers cast back to their own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v,
                                          input logic [63:0] max_v);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/pinlv_edge_sync.sv
// Three-flop synchroniser with edge detection for one asynchronous input.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   sig        : asynchronous input
//   rise       : one-cycle pulse, synchronised input went 0->1
//   fall       : one-cycle pulse, synchronised input went 1->0
//   level      : synchronised level (second flop)
module pinlv_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall,
  output logic level
);

  // sync_q[0] = s0, sync_q[1] = s1, sync_q[2] = s2
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], sig};
    end
  end

  assign rise  =  sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] &  sync_q[2];
  assign level =  sync_q[1];

endmodule

// File: rtl/pro_pinlv.sv
// Frequency / period / duty / phase meter for two asynchronous square waves.
// All results are in system-clock cycles.
// Ports:
//   clk, rst_n              : system clock, asynchronous active-low reset
//   sig_in, sig_in1         : reference and second channel (asynchronous)
//   period_cnt, high_cnt    : last sig_in period and its high time
//   meas_valid              : one-cycle strobe, period_cnt/high_cnt updated
//   phase_cnt, phase_valid  : sig_in rise -> next sig_in1 rise delay + strobe
//   freq_cnt, freq_valid    : sig_in rises in the last gate + gate-end strobe
//   no_sig, no_sig1         : channel absent (idle timeout)
module pro_pinlv
  import pinlv_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned GATE_CYCLES    = GATE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             sig_in1,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             phase_valid,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_valid,
  output logic             no_sig,
  output logic             no_sig1
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  // Idle counters must be able to hold TIMEOUT_CYCLES itself.
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), 64'(CNT_MAX)));
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic rise0, fall0, lvl0;
  logic rise1, fall1, lvl1;

  pinlv_edge_sync u_sync0 (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (sig_in),
    .rise  (rise0),
    .fall  (fall0),
    .level (lvl0)
  );

  pinlv_edge_sync u_sync1 (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (sig_in1),
    .rise  (rise1),
    .fall  (fall1),
    .level (lvl1)
  );

  // Only rises and the reference level drive the measurements.
  logic unused_sync;
  assign unused_sync = fall0 ^ fall1 ^ lvl1;

  // ---------------------------------------------------------------------------
  // Channel presence FSMs and idle counters
  // ---------------------------------------------------------------------------
  ch_state_t         st0_q, st0_d, st1_q, st1_d;
  logic [IDLE_W-1:0] idle0_q, idle1_q;
  logic              tmo0, tmo1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0_q <= CH_WAIT;
      st1_q <= CH_WAIT;
    end else begin
      st0_q <= st0_d;
      st1_q <= st1_d;
    end
  end

  always_comb begin
    // A rise in the timeout cycle wins: the channel is still alive.
    tmo0  = !rise0 && (st0_q != CH_LOST) && (idle0_q == IDLE_LAST);
    tmo1  = !rise1 && (st1_q != CH_LOST) && (idle1_q == IDLE_LAST);
    st0_d = st0_q;
    st1_d = st1_q;
    if (rise0) begin
      st0_d = CH_ARMED;
    end else if (tmo0) begin
      st0_d = CH_LOST;
    end
    if (rise1) begin
      st1_d = CH_ARMED;
    end else if (tmo1) begin
      st1_d = CH_LOST;
    end
  end

  // Idle counters freeze once the channel is declared lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle0_q <= '0;
      idle1_q <= '0;
    end else begin
      if (rise0) begin
        idle0_q <= '0;
      end else if (st0_q != CH_LOST) begin
        idle0_q <= idle0_q + IDLE_W'(1);
      end
      if (rise1) begin
        idle1_q <= '0;
      end else if (st1_q != CH_LOST) begin
        idle1_q <= idle1_q + IDLE_W'(1);
      end
    end
  end

  assign no_sig  = (st0_q == CH_LOST);
  assign no_sig1 = (st1_q == CH_LOST);

  // ---------------------------------------------------------------------------
  // Period / high time, phase and gated frequency counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  p_cnt, h_cnt, ph_cnt, e_cnt;
  logic              ph_armed;
  logic [GATE_W-1:0] gate_cnt;
  logic              armed0;

  assign armed0 = (st0_q == CH_ARMED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_cnt       <= '0;
      h_cnt       <= '0;
      ph_cnt      <= '0;
      e_cnt       <= '0;
      ph_armed    <= 1'b0;
      gate_cnt    <= '0;
      period_cnt  <= '0;
      high_cnt    <= '0;
      meas_valid  <= 1'b0;
      phase_cnt   <= '0;
      phase_valid <= 1'b0;
      freq_cnt    <= '0;
      freq_valid  <= 1'b0;
    end else begin
      meas_valid  <= 1'b0;
      phase_valid <= 1'b0;
      freq_valid  <= 1'b0;

      // The rise cycle itself is high, hence h_cnt restarts at 1.
      if (rise0) begin
        p_cnt <= '0;
        h_cnt <= CNT_W'(1);
      end else begin
        p_cnt <= cnt_inc(p_cnt);
        if (lvl0) begin
          h_cnt <= cnt_inc(h_cnt);
        end
      end

      if (rise0 && armed0) begin
        period_cnt <= cnt_inc(p_cnt);
        high_cnt   <= h_cnt;
        meas_valid <= 1'b1;
      end else if (tmo0) begin
        period_cnt <= '0;
        high_cnt   <= '0;
      end

      // A coincident sig_in1 rise closes the running measurement before the
      // new sig_in rise re-arms it.
      if (rise1 && ph_armed) begin
        phase_cnt   <= cnt_inc(ph_cnt);
        phase_valid <= 1'b1;
      end
      if (rise0) begin
        ph_cnt   <= '0;
        ph_armed <= 1'b1;
      end else if (tmo0 || (rise1 && ph_armed)) begin
        ph_armed <= 1'b0;
      end else if (ph_armed) begin
        ph_cnt <= cnt_inc(ph_cnt);
      end

      if (gate_cnt == GATE_LAST) begin
        gate_cnt   <= '0;
        freq_cnt   <= rise0 ? cnt_inc(e_cnt) : e_cnt;
        freq_valid <= 1'b1;
        e_cnt      <= '0;
      end else begin
        gate_cnt <= gate_cnt + GATE_W'(1);
        if (rise0) begin
          e_cnt <= cnt_inc(e_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_pro_pinlv.sv
// Self-checking bench for pro_pinlv. Inputs are generated on a 10 ns tick
// grid offset from the clock edges; the reference model works from the
// recorded per-edge input samples and computes every result arithmetically
// from the measurement rules (edge-index differences, window sums).
module tb_pro_pinlv;

  localparam int G  = 75;
  localparam int T  = 100;
  localparam int W  = 32;
  localparam int HN = 16384;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sig_in = 1'b0;
  logic         sig_in1 = 1'b0;
  logic [W-1:0] period_cnt, high_cnt, phase_cnt, freq_cnt;
  logic         meas_valid, phase_valid, freq_valid, no_sig, no_sig1;

  pro_pinlv #(
    .CNT_W          (W),
    .GATE_CYCLES    (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sig_in      (sig_in),
    .sig_in1     (sig_in1),
    .period_cnt  (period_cnt),
    .high_cnt    (high_cnt),
    .meas_valid  (meas_valid),
    .phase_cnt   (phase_cnt),
    .phase_valid (phase_valid),
    .freq_cnt    (freq_cnt),
    .freq_valid  (freq_valid),
    .no_sig      (no_sig),
    .no_sig1     (no_sig1)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus generator
  //   mode 0: sig_in 150 ns period (100 low / 50 high), sig_in1 held high
  //   mode 1: same sig_in, sig_in1 = sig_in delayed 40 ns
  //   mode 2: random independent durations, occasional gaps beyond timeout
  //   mode 3: sig_in stopped low, sig_in1 still follows delayed sig_in
  // ---------------------------------------------------------------------------
  int         mode = 2;
  int         tick_ph = 0;
  logic [3:0] dl = '0;
  int         rem0 = 0;
  int         rem1 = 0;

  initial begin
    #5;
    forever begin
      tick_ph = (tick_ph + 1) % 15;
      case (mode)
        0: begin
          sig_in  = (tick_ph >= 10);
          sig_in1 = 1'b1;
        end
        1: begin
          sig_in  = (tick_ph >= 10);
          sig_in1 = dl[3];
        end
        2: begin
          if (rem0 <= 0) begin
            sig_in = ~sig_in;
            rem0 = ($urandom_range(0, 19) == 0) ? 230 : int'($urandom_range(2, 40));
          end
          if (rem1 <= 0) begin
            sig_in1 = ~sig_in1;
            rem1 = ($urandom_range(0, 19) == 0) ? 230 : int'($urandom_range(2, 40));
          end
          rem0--;
          rem1--;
        end
        default: begin
          sig_in  = 1'b0;
          sig_in1 = dl[3];
        end
      endcase
      dl = {dl[2:0], sig_in};
      #10;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle comparison
  // ---------------------------------------------------------------------------
  bit     hist0 [HN];
  bit     hist1 [HN];
  bit     rh0   [HN];
  int     cyc = 0;
  bit     armed0, nosig0, nosig1, ph_armed;
  int     last0, ref0, ref1, ph_start;
  longint e_period, e_high, e_phase, e_freq;
  bit     e_mv, e_pv, e_fv;
  int     prev_mode, steady_start, prev_p, prev_h;
  bit     steady;

  // Sample of channel ch at edge i; edges before release read as 0 because
  // the synchroniser flops are cleared by reset.
  function automatic bit hv(input bit ch, input int i);
    if (i < 1) return 1'b0;
    return ch ? hist1[i] : hist0[i];
  endfunction

  task automatic model_reset();
    cyc = 0;
    armed0 = 0; nosig0 = 0; nosig1 = 0; ph_armed = 0;
    last0 = 0; ref0 = 0; ref1 = 0; ph_start = 0;
    e_period = 0; e_high = 0; e_phase = 0; e_freq = 0;
    e_mv = 0; e_pv = 0; e_fv = 0;
    steady_start = 0; prev_p = -1; prev_h = 0; prev_mode = mode;
  endtask

  task automatic model_step(input int c);
    bit r0, r1;
    r0 = hv(0, c - 2) && !hv(0, c - 3);
    r1 = hv(1, c - 2) && !hv(1, c - 3);
    rh0[c] = r0;
    e_mv = 0; e_pv = 0; e_fv = 0;
    if (r1 && ph_armed) begin
      e_phase = c - ph_start;
      e_pv = 1;
      ph_armed = 0;
    end
    if (r0) begin
      ph_armed = 1;
      ph_start = c;
    end
    if (r0) begin
      if (armed0) begin
        e_period = c - last0;
        e_high = 0;
        for (int k = last0 - 2; k <= c - 3; k++) e_high += hv(0, k);
        e_mv = 1;
      end
      armed0 = 1; last0 = c; ref0 = c; nosig0 = 0;
    end else if (!nosig0 && (c - ref0 == T)) begin
      nosig0 = 1; e_period = 0; e_high = 0; armed0 = 0; ph_armed = 0;
    end
    if (r1) begin
      ref1 = c; nosig1 = 0;
    end else if (!nosig1 && (c - ref1 == T)) begin
      nosig1 = 1;
    end
    if (c % G == 0) begin
      e_freq = 0;
      for (int k = c - G + 1; k <= c; k++) e_freq += rh0[k];
      e_fv = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
        #1;
        check("rst_period", 64'(period_cnt), 0);
        check("rst_high", 64'(high_cnt), 0);
        check("rst_phase", 64'(phase_cnt), 0);
        check("rst_freq", 64'(freq_cnt), 0);
        check("rst_strobes", 64'({meas_valid, phase_valid, freq_valid}), 0);
        check("rst_flags", 64'({no_sig, no_sig1}), 0);
      end else begin
        cyc++;
        if (cyc >= HN) begin
          $display("FAIL history_overflow: got %0d, expected below %0d", cyc, HN);
          $fatal(1, "history overflow");
        end
        hist0[cyc] = sig_in;
        hist1[cyc] = sig_in1;
        model_step(cyc);
        #1;
        check("meas_valid", 64'(meas_valid), 64'(e_mv));
        check("period_cnt", 64'(period_cnt), e_period);
        check("high_cnt", 64'(high_cnt), e_high);
        check("phase_valid", 64'(phase_valid), 64'(e_pv));
        check("phase_cnt", 64'(phase_cnt), e_phase);
        check("freq_valid", 64'(freq_valid), 64'(e_fv));
        check("freq_cnt", 64'(freq_cnt), e_freq);
        check("no_sig", 64'(no_sig), 64'(nosig0));
        check("no_sig1", 64'(no_sig1), 64'(nosig1));

        // Closed-form properties of the steady 150 ns waveform.
        if (mode != prev_mode) begin
          prev_mode = mode;
          steady_start = cyc;
          prev_p = -1;
        end
        steady = (mode <= 1) && (cyc - steady_start > G + 10);
        if (steady && meas_valid) begin
          if (prev_p >= 0) begin
            check("period_pair_sum", 64'(int'(period_cnt) + prev_p), 15);
            check("high_pair_sum", 64'(int'(high_cnt) + prev_h), 5);
          end
          prev_p = int'(period_cnt);
          prev_h = int'(high_cnt);
        end
        if (steady && freq_valid) check("freq_steady", 64'(freq_cnt), 10);
        if (steady && mode == 1 && phase_valid) check("phase_40ns", 64'(phase_cnt), 2);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    // Reset held 100 ns with random toggling inputs.
    mode = 2;
    #100;
    mode = 0;
    @(negedge clk); @(negedge clk);
    #3 rst_n = 1'b1;
    run_cycles(400);

    mode = 1;
    run_cycles(300);

    mode = 3;
    run_cycles(150);

    mode = 1;
    run_cycles(200);

    // Asynchronous reset in the middle of a period.
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_period", 64'(period_cnt), 0);
    check("async_high", 64'(high_cnt), 0);
    check("async_phase", 64'(phase_cnt), 0);
    check("async_freq", 64'(freq_cnt), 0);
    check("async_flags", 64'({meas_valid, phase_valid, freq_valid, no_sig, no_sig1}), 0);
    run_cycles(3);
    @(negedge clk);
    #3 rst_n = 1'b1;
    run_cycles(200);

    mode = 2;
    run_cycles(3000);

    mode = 1;
    run_cycles(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
